// File: rtl/jump_input_cond.sv
// Jump pushbutton conditioner: synchronizes and debounces the raw button, then
// turns each accepted press into a jump request that spans at least one full frame.
module jump_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        screen_end,
    output logic        io_jump,
    output logic        btn_level,
    output logic [15:0] press_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PENDING      = 2'd1,
        HOLD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [19:0] cnt;
    logic        level_d;
    logic        screen_d;
    logic        press_ev;
    logic        tick_ev;
    state_t      state;

    // Two-flop synchronizer; sync2 is the sampled level the debouncer works on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // The count tracks how long the sampled level has disagreed with btn_level;
    // any agreement (a bounce) restarts it from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (sync2 == btn_level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            btn_level <= sync2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_d  <= 1'b0;
            screen_d <= 1'b0;
        end else begin
            level_d  <= btn_level;
            screen_d <= screen_end;
        end
    end

    assign press_ev  = btn_level & ~level_d;
    assign tick_ev   = screen_end & ~screen_d;
    assign state_dbg = state;

    // io_jump is registered alongside the state so it is high exactly in PENDING/HOLD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            io_jump     <= 1'b0;
            press_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_ev) begin
                        state       <= PENDING;
                        io_jump     <= 1'b1;
                        press_count <= press_count + 16'd1;
                    end
                end
                PENDING: begin
                    if (tick_ev) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick_ev) begin
                        io_jump <= 1'b0;
                        state   <= btn_level ? WAIT_RELEASE : IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!btn_level) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    io_jump <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_input_cond.sv
// Bench for jump_input_cond: directed edge-exact scenarios plus randomized button
// and frame activity, checked every cycle against a behavioural model.
module tb_jump_input_cond;

    localparam int N = 4;
    localparam int M_IDLE = 0, M_PENDING = 1, M_HOLD = 2, M_WAIT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        btn_raw;
    logic        screen_end;
    logic        io_jump;
    logic        btn_level;
    logic [15:0] press_count;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_rawq[2];
    bit          m_shist[$];
    bit          m_level, m_level_d, m_screen_d, m_jump;
    int          m_mode;
    logic [15:0] m_count;
    logic [15:0] exp_q[$];
    logic [15:0] seen_count;

    always #5 clock = ~clock;

    jump_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .screen_end  (screen_end),
        .io_jump     (io_jump),
        .btn_level   (btn_level),
        .press_count (press_count),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rawq[0] = 1'b0;
        m_rawq[1] = 1'b0;
        m_shist.delete();
        for (int i = 0; i < N; i++) m_shist.push_back(1'b0);
        m_level    = 1'b0;
        m_level_d  = 1'b0;
        m_screen_d = 1'b0;
        m_jump     = 1'b0;
        m_mode     = M_IDLE;
        m_count    = 16'd0;
        exp_q.delete();
        seen_count = 16'd0;
    endtask

    // Level flips once the last N sampled values all disagree with it.
    task automatic model_step();
        bit s, nl, press, tick, all_diff;
        s         = m_rawq[1];
        m_rawq[1] = m_rawq[0];
        m_rawq[0] = btn_raw;
        m_shist.push_back(s);
        if (m_shist.size() > N) m_shist.delete(0);
        all_diff = (m_shist.size() == N);
        foreach (m_shist[i]) if (m_shist[i] == m_level) all_diff = 1'b0;
        nl    = all_diff ? ~m_level : m_level;
        press = m_level && !m_level_d;
        tick  = screen_end && !m_screen_d;
        case (m_mode)
            M_IDLE: if (press) begin
                m_mode  = M_PENDING;
                m_count = m_count + 16'd1;
                exp_q.push_back(m_count);
            end
            M_PENDING: if (tick) m_mode = M_HOLD;
            M_HOLD:    if (tick) m_mode = m_level ? M_WAIT : M_IDLE;
            default:   if (!m_level) m_mode = M_IDLE;
        endcase
        m_jump     = (m_mode == M_PENDING) || (m_mode == M_HOLD);
        m_level_d  = m_level;
        m_level    = nl;
        m_screen_d = screen_end;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Compare process: outputs against the model every cycle, plus press sequence.
    always @(negedge clock) begin
        if (!reset) begin
            check("btn_level", 16'(btn_level), 16'(m_level));
            check("io_jump", 16'(io_jump), 16'(m_jump));
            check("press_count", press_count, m_count);
            if (press_count !== seen_count) begin
                if (exp_q.size() == 0) check("press_seq_extra", press_count, seen_count);
                else check("press_seq", press_count, exp_q.pop_front());
                seen_count = press_count;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick_pulse();
        screen_end = 1'b1;
        step(3);
        screen_end = 1'b0;
        step(3);
    endtask

    initial begin
        int hold_left;
        btn_raw    = 1'b0;
        screen_end = 1'b0;
        reset      = 1'b1;
        #3;
        check("reset_io_jump", 16'(io_jump), 16'd0);
        check("reset_btn_level", 16'(btn_level), 16'd0);
        check("reset_press_count", press_count, 16'd0);
        step(2);
        reset = 1'b0;

        // Clean press: level at edge N+2, io_jump one edge later.
        btn_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            check("press_btn_level_edge", 16'(btn_level), 16'(e >= 6));
            check("press_io_jump_edge", 16'(io_jump), 16'(e >= 7));
        end
        check("press_count_first", press_count, 16'd1);

        // Release, then two frame ticks return to idle.
        btn_raw = 1'b0;
        step(10);
        check("pending_io_jump", 16'(io_jump), 16'd1);
        tick_pulse();
        check("hold_io_jump", 16'(io_jump), 16'd1);
        tick_pulse();
        check("idle_io_jump", 16'(io_jump), 16'd0);
        check("idle_press_count", press_count, 16'd1);

        // Short bounces never reach the debounce threshold.
        repeat (5) begin
            btn_raw = 1'b1;
            step(3);
            btn_raw = 1'b0;
            step(3);
        end
        step(6);
        check("bounce_btn_level", 16'(btn_level), 16'd0);
        check("bounce_io_jump", 16'(io_jump), 16'd0);
        check("bounce_press_count", press_count, 16'd1);

        // Held through the second tick: no auto-repeat.
        btn_raw = 1'b1;
        step(10);
        tick_pulse();
        tick_pulse();
        check("held_io_jump", 16'(io_jump), 16'd0);
        check("held_state", 16'(state_dbg), 16'd3);
        step(20);
        check("held_press_count", press_count, 16'd2);
        btn_raw = 1'b0;
        step(10);
        check("released_state", 16'(state_dbg), 16'd0);

        // Button held across reset release counts as a new press.
        btn_raw = 1'b1;
        reset   = 1'b1;
        step(2);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step(1);
            check("rst_held_btn_level", 16'(btn_level), 16'(e >= 6));
        end
        check("rst_held_press_count", press_count, 16'd1);
        check("rst_held_io_jump", 16'(io_jump), 16'd1);
        btn_raw = 1'b0;
        step(10);
        tick_pulse();

        // Asynchronous reset while in HOLD clears outputs without a clock edge.
        check("pre_reset_state_hold", 16'(state_dbg), 16'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_io_jump", 16'(io_jump), 16'd0);
        check("async_reset_press_count", press_count, 16'd0);
        step(2);
        reset = 1'b0;
        step(2);

        // Counter wrap from 0xFFFF.
        force dut.press_count = 16'hFFFF;
        m_count    = 16'hFFFF;
        seen_count = 16'hFFFF;
        #1;
        release dut.press_count;
        step(1);
        btn_raw = 1'b1;
        step(10);
        check("wrap_press_count", press_count, 16'h0000);
        btn_raw = 1'b0;
        step(10);
        tick_pulse();
        tick_pulse();

        // Randomized button, frame and occasional reset activity.
        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left == 0) begin
                btn_raw   = ($urandom_range(0, 1) == 1);
                hold_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
            end
            hold_left--;
            if ($urandom_range(0, 7) == 0) screen_end = ~screen_end;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end
            step(1);
        end

        btn_raw    = 1'b0;
        screen_end = 1'b0;
        step(20);
        check("press_queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_input_cond.md
JUMP_INPUT_COND -- requirements
Module: jump_input_cond

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced level changes; legal range 1 to 2^20-1.
REQ-002 Port: clock  input  1  master clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: btn_raw  input  1  raw jump pushbutton, asynchronous to clock, bouncy; 1 = pressed.
REQ-005 Port: screen_end  input  1  display-controller level, synchronous to clock, high during vertical blanking; its rising edge is the frame tick.
REQ-006 Port: io_jump  output  1  jump request to the processor's jio instruction; registered.
REQ-007 Port: btn_level  output  1  debounced button level; registered.
REQ-008 Port: press_count  output  16  count of accepted presses; registered.

Function
REQ-009 Synchronizer: btn_raw SHALL pass through two flip-flops; the second stage is the sampled level s.
REQ-010 Debounce: a 20-bit counter SHALL clear on any cycle with s == btn_level and increment on any cycle with s != btn_level.
REQ-011 btn_level SHALL take the value of s, and the counter SHALL clear, on the edge where s has differed from btn_level for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 Debounce latency: a clean, held change on btn_raw SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 rising edges later.
REQ-013 A bounce of s back to btn_level before the count completes SHALL restart the count from zero; btn_level SHALL NOT change.
REQ-014 Press event: btn_level high and its one-cycle-delayed copy low; frame tick: screen_end high and its one-cycle-delayed copy low.
REQ-015 FSM states: IDLE, PENDING, HOLD, WAIT_RELEASE; encoding free.
REQ-016 IDLE -> PENDING on a press event; all other cycles stay in IDLE.
REQ-017 PENDING -> HOLD on a frame tick; otherwise stay.
REQ-018 HOLD -> WAIT_RELEASE on a frame tick if btn_level = 1; HOLD -> IDLE on a frame tick if btn_level = 0; otherwise stay.
REQ-019 WAIT_RELEASE -> IDLE when btn_level = 0; otherwise stay. No auto-repeat while held.
REQ-020 io_jump SHALL be 1 exactly when the registered state is PENDING or HOLD; it therefore rises one cycle after the press event and spans at least one full frame.
REQ-021 Press event and frame tick in the same cycle while in IDLE: go to PENDING; the tick is not counted toward HOLD.
REQ-022 Press events in PENDING, HOLD or WAIT_RELEASE SHALL be ignored and SHALL NOT be counted.
REQ-023 press_count SHALL increment by 1 on each IDLE -> PENDING transition, modulo 2^16 (0xFFFF -> 0x0000).

Reset
REQ-024 While reset = 1, independent of clock: synchronizer flops = 0, debounce counter = 0, btn_level = 0, delayed copies = 0, state = IDLE, io_jump = 0, press_count = 0.
REQ-025 Reset asserted mid-operation (any state, mid-count) SHALL abort it immediately; no partial press is retained.
REQ-026 If btn_raw is held high across reset release, btn_level rises DEBOUNCE_CYCLES+2 edges after release and this SHALL count as a new press.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 btn_raw 0->1 held, screen_end low -> btn_level = 1 at edge 6, io_jump = 1 at edge 7, press_count = 1.
REQ-028 btn_raw high for 3 cycles then low, repeated 5 times -> btn_level stays 0, io_jump stays 0, press_count stays 0.
REQ-029 Accepted press, then screen_end ticks at edges 20 and 40 with button released -> io_jump = 1 from edge 7 through edge 40, then 0 (state returns to IDLE).
REQ-030 Button held through the second tick -> io_jump = 0 after the second tick, with no new press until release plus a re-press; press_count increments only once.
REQ-031 press_count preloaded to 0xFFFF by 65535 presses, then one more press -> press_count = 0x0000.
REQ-032 Reset pulse while in HOLD -> io_jump = 0 and press_count = 0 in the same cycle, without waiting for a clock edge.
